// File: rtl/sm_rot_pkg.sv
// sm_rot_pkg: shared word/shift/tag types and a reference rotate for the SM3/SM2 rotate-right pipeline
package sm_rot_pkg;
   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;
   localparam int TAG_W   = 4;
   typedef logic [DATA_W-1:0]  word_t;
   typedef logic [SHAMT_W-1:0] shamt_t;
   typedef logic [TAG_W-1:0]   tag_t;
   // a zero amount shifts the left term by DATA_W, which yields zero, so the word passes unchanged
   function automatic word_t rotr(word_t w, shamt_t s);
      return (w >> s) | (w << (DATA_W - int'(s)));
   endfunction
endpackage

// File: rtl/rotr_stage.sv
// rotr_stage: combinational rotate-right of a word by STEP*amt_i bit positions
//   data_i  word to rotate
//   amt_i   rotate amount in units of STEP
//   data_o  rotated word
module rotr_stage
   import sm_rot_pkg::*;
#(
   parameter int STEP  = 1,
   parameter int AMT_W = 3
) (
   input  word_t            data_i,
   input  logic [AMT_W-1:0] amt_i,
   output word_t            data_o
);
   assign data_o = (data_i >> (STEP * int'(amt_i))) | (data_i << (DATA_W - STEP * int'(amt_i)));
endmodule

// File: rtl/rotr_pipe.sv
// rotr_pipe: two-stage pipelined 32-bit rotate-right with valid/ready flow control and tag sideband
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    input handshake; in_data, in_shamt, in_tag travel together
//   in_dir               only with ROTR_BIDIR_EN defined: 0 = rotate right, 1 = rotate left
//   out_valid/out_ready  output handshake; out_data, out_tag held stable while stalled
//   busy                 any stage holds a valid word
module rotr_pipe
   import sm_rot_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   output logic   in_ready,
   input  word_t  in_data,
   input  shamt_t in_shamt,
   input  tag_t   in_tag,
`ifdef ROTR_BIDIR_EN
   input  logic   in_dir,
`endif
   output logic   out_valid,
   input  logic   out_ready,
   output word_t  out_data,
   output tag_t   out_tag,
   output logic   busy
);
   shamt_t     amt;
   word_t      coarse, fine;
   logic       s1_adv, s2_adv;
   logic       s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   word_t      s1_data_q, s1_data_d, s2_data_q, s2_data_d;
   logic [2:0] s1_fine_q, s1_fine_d;
   tag_t       s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
`ifdef ROTR_BIDIR_EN
   // a left rotate by n equals a right rotate by (DATA_W - n) mod DATA_W
   assign amt = in_dir ? shamt_t'(0) - in_shamt : in_shamt;
`else
   assign amt = in_shamt;
`endif
   rotr_stage #(.STEP(8), .AMT_W(2)) u_coarse (
      .data_i (in_data),
      .amt_i  (amt[SHAMT_W-1:3]),
      .data_o (coarse)
   );
   rotr_stage #(.STEP(1), .AMT_W(3)) u_fine (
      .data_i (s1_data_q),
      .amt_i  (s1_fine_q),
      .data_o (fine)
   );
   always_comb begin
      s2_adv     = !s2_valid_q || out_ready;
      s1_adv     = !s1_valid_q || s2_adv;
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      s1_data_d  = (s1_adv && in_valid) ? coarse : s1_data_q;
      s1_fine_d  = (s1_adv && in_valid) ? amt[2:0] : s1_fine_q;
      s1_tag_d   = (s1_adv && in_valid) ? in_tag : s1_tag_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      s2_data_d  = (s2_adv && s1_valid_q) ? fine : s2_data_q;
      s2_tag_d   = (s2_adv && s1_valid_q) ? s1_tag_q : s2_tag_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_fine_q  <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_fine_q  <= s1_fine_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
      end
   end
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_rotr_pipe.sv
// tb_rotr_pipe: directed vectors, corner sequences and randomized traffic against a bit-level rotate model
module tb_rotr_pipe;
   import sm_rot_pkg::*;
`ifdef ROTR_BIDIR_EN
   localparam bit BIDIR = 1'b1;
`else
   localparam bit BIDIR = 1'b0;
`endif
   typedef struct { word_t d; shamt_t s; tag_t t; logic dir; word_t exp; } vec_t;
   typedef struct { word_t d; tag_t t; } exp_t;
   logic   clk = 1'b0, rst = 1'b1;
   logic   in_valid = 1'b0, out_ready = 1'b1, drv_dir = 1'b0;
   logic   in_ready, out_valid, busy;
   word_t  in_data = '0, out_data;
   shamt_t in_shamt = '0;
   tag_t   in_tag = '0, out_tag;
   int     checks = 0, failures = 0;
   int     acc, seen;
   exp_t   q[$];
   vec_t   tbl[$];
   word_t  bw[6];
   logic   stall_q = 1'b0;
   word_t  hold_d = '0;
   tag_t   hold_t = '0;
   always #5 clk = ~clk;
   rotr_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_tag    (in_tag),
`ifdef ROTR_BIDIR_EN
      .in_dir    (drv_dir),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
   );
   // output bit i takes input bit (i+n) mod W for a right rotate by n
   function automatic word_t ref_rot(word_t d, int s, logic dir);
      word_t r;
      int n;
      n = dir ? (DATA_W - s) % DATA_W : s;
      for (int i = 0; i < DATA_W; i++) r[i] = d[(i + n) % DATA_W];
      return r;
   endfunction
   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask
   task automatic drive(logic v, word_t d, shamt_t s, tag_t t, logic dir);
      in_valid = v;
      in_data  = d;
      in_shamt = s;
      in_tag   = t;
      drv_dir  = dir;
   endtask
   task automatic idle();
      in_valid = 1'b0;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drain(string name);
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 50) begin
         step();
         n++;
      end
      check(name, (q.size() == 0 && !busy), 1);
   endtask
   // scoreboard: record every accepted word, flush on reset
   always @(posedge clk) begin
      if (rst) q.delete();
      else if (in_valid && in_ready) q.push_back('{ref_rot(in_data, int'(in_shamt), drv_dir), in_tag});
   end
   // output monitor: ordering, values and stability under backpressure
   always @(posedge clk) begin
      if (!rst && stall_q) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, hold_d);
         check("hold_tag", out_tag, hold_t);
      end
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=0x%0h required=no_output", out_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_data", out_data, e.d);
            check("out_tag", out_tag, e.t);
         end
      end
      stall_q <= !rst && out_valid && !out_ready;
      hold_d  <= out_data;
      hold_t  <= out_tag;
   end
   initial begin
      tbl.push_back('{32'h80000001, 5'd1,  4'h3, 1'b0, 32'hC0000000});
      tbl.push_back('{32'h12345678, 5'd8,  4'hA, 1'b0, 32'h78123456});
      tbl.push_back('{32'hDEADBEEF, 5'd0,  4'h1, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{32'h00000001, 5'd31, 4'h5, 1'b0, 32'h00000002});
      tbl.push_back('{32'h12345678, 5'd4,  4'h6, 1'b0, 32'h81234567});
      tbl.push_back('{32'hF0000000, 5'd28, 4'hC, 1'b0, 32'h0000000F});
      tbl.push_back('{32'h00000001, 5'd16, 4'hF, 1'b0, 32'h00010000});
      if (BIDIR) begin
         tbl.push_back('{32'h80000001, 5'd1,  4'h7, 1'b1, 32'h00000003});
         tbl.push_back('{32'h12345678, 5'd8,  4'h2, 1'b1, 32'h34567812});
         tbl.push_back('{32'hDEADBEEF, 5'd0,  4'h9, 1'b1, 32'hDEADBEEF});
      end
      repeat (3) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      foreach (tbl[k]) begin
         drive(1'b1, tbl[k].d, tbl[k].s, tbl[k].t, tbl[k].dir);
         step();
         idle();
         check($sformatf("vec%0d_lat1_valid", k), out_valid, 0);
         step();
         check($sformatf("vec%0d_valid", k), out_valid, 1);
         check($sformatf("vec%0d_data", k), out_data, tbl[k].exp);
         check($sformatf("vec%0d_tag", k), out_tag, tbl[k].t);
         step();
      end
      drain("vec_drain");
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            drive(1'b1, word_t'($urandom), shamt_t'($urandom), tag_t'(i), 1'b0);
            #1;
            check("stream_in_ready", in_ready, 1);
         end else idle();
         step();
         if (i >= 1 && i <= 16) check($sformatf("stream_valid%0d", i), out_valid, 1);
      end
      drain("stream_drain");
      foreach (bw[i]) bw[i] = word_t'($urandom);
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, bw[acc], 5'd3, tag_t'(acc), 1'b0);
         #1;
         if (in_ready) acc++;
         step();
      end
      check("bp_accepted", acc, 2);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, ref_rot(bw[0], 3, 1'b0));
      out_ready = 1'b1;
      #1;
      check("bp_ready_comb", in_ready, 1);
      step();
      idle();
      drain("bp_drain");
      out_ready = 1'b0;
      drive(1'b1, 32'hA5A5A5A5, 5'd7, 4'h3, 1'b0);
      step();
      drive(1'b1, 32'h5A5A5A5A, 5'd9, 4'hA, 1'b0);
      step();
      idle();
      check("mid_busy", busy, 1);
      check("mid_out_valid", out_valid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         step();
         if (out_valid) seen++;
      end
      check("mid_rst_no_ghost", seen, 0);
      for (int c = 0; c < 10000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 2) != 0, word_t'($urandom), shamt_t'($urandom), tag_t'($urandom),
               BIDIR ? logic'($urandom_range(0, 1)) : 1'b0);
         step();
      end
      idle();
      out_ready = 1'b1;
      drain("rand_drain");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
